irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 121 ++++++++++++
 tb/tb_irq_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-level interrupt arbiter that offers MEI/MSI/MTI to the trap path.
// Define IRQ_EXT_SYNC_EN to route external_interrupt through a 2-flop synchronizer.
module irq_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        software_interrupt,
   input  logic        timer_interrupt,
   input  logic        external_interrupt,
   input  logic        i_mie_msie,
   input  logic        i_mie_mtie,
   input  logic        i_mie_meie,
   input  logic        i_mstatus_mie,
   input  logic        exception_pending,
   input  logic        pipe_ready,
   input  logic        trap_ack,
   output logic [2:0]  o_mip,
   output logic        irq_req,
   output logic [3:0]  irq_code,
   output logic [15:0] o_irq_count
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_COOL = 2'd2
   } state_t;

   localparam logic [3:0] CODE_MSI = 4'd3;
   localparam logic [3:0] CODE_MTI = 4'd7;
   localparam logic [3:0] CODE_MEI = 4'd11;

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_mip;
   logic [3:0]  r_code, w_code_nxt, w_prio_code;
   logic [15:0] r_irq_count;
   logic        w_ext, w_lat_elig, w_ack;
   logic [2:0]  w_elig;

`ifdef IRQ_EXT_SYNC_EN
   logic r_ext_s1, r_ext_s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ext_s1 <= 1'b0;
         r_ext_s2 <= 1'b0;
      end else begin
         r_ext_s1 <= external_interrupt;
         r_ext_s2 <= r_ext_s1;
      end
   end

   assign w_ext = r_ext_s2;
`else
   assign w_ext = external_interrupt;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_mip <= 3'b000;
      else     r_mip <= {w_ext, timer_interrupt, software_interrupt};
   end

   assign w_elig = r_mip & {i_mie_meie, i_mie_mtie, i_mie_msie};

   // Fixed priority MEI > MSI > MTI; only meaningful when some bit of w_elig is set
   always_comb begin
      w_prio_code = CODE_MTI;
      if (w_elig[2])      w_prio_code = CODE_MEI;
      else if (w_elig[0]) w_prio_code = CODE_MSI;
   end

   always_comb begin
      w_lat_elig = 1'b0;
      case (r_code)
         CODE_MEI: w_lat_elig = w_elig[2];
         CODE_MSI: w_lat_elig = w_elig[0];
         CODE_MTI: w_lat_elig = w_elig[1];
         default:  w_lat_elig = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      w_ack       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if ((|w_elig) && i_mstatus_mie && pipe_ready && !exception_pending) begin
               w_state_nxt = ST_REQ;
               w_code_nxt  = w_prio_code;
            end
         end
         ST_REQ: begin
            // An ack wins over a simultaneous withdraw
            if (trap_ack) begin
               w_state_nxt = ST_COOL;
               w_ack       = 1'b1;
            end else if (!w_lat_elig || !i_mstatus_mie) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_COOL: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_code      <= 4'd0;
         r_irq_count <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         r_code  <= w_code_nxt;
         if (w_ack && (r_irq_count != 16'hFFFF)) r_irq_count <= r_irq_count + 16'd1;
      end
   end

   assign o_mip       = r_mip;
   assign irq_req     = (r_state == ST_REQ);
   assign irq_code    = r_code;
   assign o_irq_count = r_irq_count;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic checked each cycle against
// a behavioural model of the interrupt offer/acknowledge protocol.
module tb_irq_ctrl;
`ifdef IRQ_EXT_SYNC_EN
   localparam int EXT_DLY = 2;
`else
   localparam int EXT_DLY = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic sw, tm, ext, msie, mtie, meie, gmie, exc, rdy, ack;
   logic [2:0]  mip;
   logic        req;
   logic [3:0]  code;
   logic [15:0] cnt;

   always #5 clk = ~clk;

   irq_ctrl dut (
      .clk(clk), .rst(rst),
      .software_interrupt(sw), .timer_interrupt(tm), .external_interrupt(ext),
      .i_mie_msie(msie), .i_mie_mtie(mtie), .i_mie_meie(meie),
      .i_mstatus_mie(gmie), .exception_pending(exc), .pipe_ready(rdy), .trap_ack(ack),
      .o_mip(mip), .irq_req(req), .irq_code(code), .o_irq_count(cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---- reference model: sources seen one cycle late, offer/cooldown flags, counter ----
   logic [2:0] m_mip;
   bit         m_offer, m_cool;
   int         m_code, m_cnt;
   bit         ext_q[$];
   int         prio[3] = '{11, 3, 7};

   function automatic int src_of(input int c);
      if (c == 11) return 2;
      if (c == 3)  return 0;
      return 1;
   endfunction

   task automatic model_step();
      logic [2:0] el;
      bit found;
      bit ext_seen;
      el = m_mip & {meie, mtie, msie};
      if (rst) begin
         m_mip = 3'b000; m_offer = 0; m_cool = 0; m_code = 0; m_cnt = 0;
         ext_q.delete();
         for (int k = 0; k < EXT_DLY; k++) ext_q.push_back(1'b0);
         return;
      end
      if (m_offer) begin
         if (ack) begin
            m_offer = 0; m_cool = 1;
            if (m_cnt < 65535) m_cnt++;
         end else if (!el[src_of(m_code)] || !gmie) begin
            m_offer = 0;
         end
      end else if (m_cool) begin
         m_cool = 0;
      end else if (el != 3'b000 && gmie && rdy && !exc) begin
         m_offer = 1;
         found = 0;
         for (int k = 0; k < 3; k++)
            if (!found && el[src_of(prio[k])]) begin m_code = prio[k]; found = 1; end
      end
      ext_q.push_back(ext);
      ext_seen = ext_q.pop_front();
      m_mip = {ext_seen, tm, sw};
   endtask

   // One clock: compare at negedge, advance the model, return just after the next posedge
   task automatic cycle(input bit do_chk = 1);
      @(negedge clk);
      if (do_chk) begin
         chk("o_mip", 32'(mip), 32'(m_mip));
         chk("irq_req", 32'(req), 32'(m_offer));
         chk("irq_code", 32'(code), m_code);
         chk("o_irq_count", 32'(cnt), m_cnt);
      end
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      sw = 0; tm = 0; ext = 0; msie = 0; mtie = 0; meie = 0;
      gmie = 0; exc = 0; rdy = 0; ack = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      cycle();
      rst = 0;
   endtask

   task automatic wait_req(input int max, output int n);
      n = 0;
      while (!req && n < max) begin
         cycle();
         n++;
      end
      if (!req) chk("wait_req_timeout", 0, 1);
   endtask

   int n;

   initial begin
      idle_inputs();
      rst = 1;
      cycle(0);
      cycle(0);
      rst = 0;
      chk("rst_mip", 32'(mip), 0);
      chk("rst_req", 32'(req), 0);
      chk("rst_code", 32'(code), 0);
      chk("rst_cnt", 32'(cnt), 0);

      // Basic timer offer: req at cycle 2, ack at cycle 4, dropped at cycle 5
      do_reset();
      tm = 1; mtie = 1; gmie = 1; rdy = 1;
      cycle(); cycle();
      chk("mti_req_c2", 32'(req), 1);
      chk("mti_code_c2", 32'(code), 7);
      cycle(); cycle();
      ack = 1;
      cycle();
      ack = 0;
      chk("mti_req_c5", 32'(req), 0);
      chk("mti_cnt_c5", 32'(cnt), 1);
      cycle(); cycle();

      // All three eligible -> 11; after ack with external low -> 3
      do_reset();
      sw = 1; tm = 1; ext = 1; msie = 1; mtie = 1; meie = 1; gmie = 1;
      repeat (4) cycle();
      rdy = 1;
      wait_req(8, n);
      chk("all_code", 32'(code), 11);
      ack = 1; ext = 0;
      cycle();
      ack = 0; rdy = 0;
      repeat (4) cycle();
      rdy = 1;
      wait_req(8, n);
      chk("msi_next_code", 32'(code), 3);

      // Withdraw without ack, then drop with simultaneous ack
      do_reset();
      tm = 1; mtie = 1; gmie = 1; rdy = 1;
      wait_req(8, n);
      tm = 0;
      cycle(); cycle();
      chk("withdraw_req", 32'(req), 0);
      chk("withdraw_cnt", 32'(cnt), 0);
      tm = 1;
      wait_req(8, n);
      tm = 0; ack = 1;
      cycle();
      ack = 0;
      chk("ack_wins_req", 32'(req), 0);
      chk("ack_wins_cnt", 32'(cnt), 1);
      cycle(); cycle();

      // exception_pending blocks the offer only while asserted
      do_reset();
      exc = 1; tm = 1; mtie = 1; gmie = 1; rdy = 1;
      repeat (5) cycle();
      chk("exc_block_req", 32'(req), 0);
      exc = 0;
      cycle();
      chk("exc_release_req", 32'(req), 1);

      // Saturation: counter preloaded just below 0xFFFF to keep the run short
      do_reset();
      tm = 1; mtie = 1; gmie = 1; rdy = 1;
      wait_req(8, n);
      dut.r_irq_count = 16'hFFFE;
      m_cnt = 65534;
      ack = 1;
      cycle();
      ack = 0;
      chk("sat_first", 32'(cnt), 16'hFFFF);
      wait_req(8, n);
      ack = 1;
      cycle();
      ack = 0;
      chk("sat_hold", 32'(cnt), 16'hFFFF);

      // Reset while offering
      wait_req(8, n);
      rst = 1;
      cycle();
      rst = 0;
      chk("midreq_rst_mip", 32'(mip), 0);
      chk("midreq_rst_req", 32'(req), 0);
      chk("midreq_rst_code", 32'(code), 0);
      chk("midreq_rst_cnt", 32'(cnt), 0);

      // External source latency (2 direct, 4 through the synchronizer)
      do_reset();
      meie = 1; gmie = 1; rdy = 1; ext = 1;
      wait_req(10, n);
      chk("ext_latency", n, 2 + EXT_DLY);
      chk("ext_code", 32'(code), 11);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         rst  = ($urandom_range(299) == 0);
         if ($urandom_range(7) == 0)  sw   = ~sw;
         if ($urandom_range(7) == 0)  tm   = ~tm;
         if ($urandom_range(7) == 0)  ext  = ~ext;
         if ($urandom_range(15) == 0) msie = ~msie;
         if ($urandom_range(15) == 0) mtie = ~mtie;
         if ($urandom_range(15) == 0) meie = ~meie;
         if ($urandom_range(9) == 0)  gmie = ~gmie;
         exc = ($urandom_range(3) == 0);
         rdy = ($urandom_range(3) != 0);
         ack = ($urandom_range(2) == 0);
         cycle();
      end
      rst = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
